br_stats_mmio: RTL and testbench

Memory-mapped branch-prediction statistics unit that sits on the CPU's external data bus, downstream of the core. It consumes the core's per-cycle branch event pulses and counts them in 32-bit saturating counters: branches, BTB hits and mispredictions, plus a cycle counter. It serves coherent 32-bit reads over the 16-bit MMIO read path, using a hi-word shadow snapshot. Software controls it through a control register and can enable an overflow interrupt.

---
 rtl/br_stats_mmio.sv | 177 +++++++++++++++++
 tb/tb_br_stats_mmio.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/br_stats_mmio.sv
// br_stats_mmio
//   Memory-mapped branch-prediction statistics unit on the external data bus.
//   It counts resolved branches, BTB hits, mispredictions and enabled cycles in
//   32-bit saturating counters. 32-bit values are read over the 16-bit MMIO
//   path: reading a lo word snapshots that counter's upper half into a shadow
//   register, and the matching hi word returns the snapshot.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   addr[15:0]     bus address; a 16-word window at BASE_ADDR
//   mm_re          read strobe
//   mm_we          write strobe
//   wdata[15:0]    write data (only CTRL at offset 0 is writable)
//   inc_br_cnt     one pulse per resolved branch
//   inc_hit_cnt    one pulse per BTB hit
//   inc_mispr_cnt  one pulse per misprediction
//   rdata[15:0]    combinational read data, 0 when the window is not selected
//   ovf_irq        registered overflow interrupt
//
// Register map (word offsets)
//   0 CTRL   bit0 EN, bit1 CLR (self-clearing, reads 0), bit2 IRQ_EN
//   1 STATUS bits[3:0] sticky overflow: BR, HIT, MISPR, CYC
//   2/3 BR lo/hi, 4/5 HIT lo/hi, 6/7 MISPR lo/hi, 8/9 CYC lo/hi, 10-15 read 0
module br_stats_mmio #(
   parameter logic [15:0] BASE_ADDR = 16'hC010
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        mm_re,
   input  logic        mm_we,
   input  logic [15:0] wdata,
   input  logic        inc_br_cnt,
   input  logic        inc_hit_cnt,
   input  logic        inc_mispr_cnt,
   output logic [15:0] rdata,
   output logic        ovf_irq
);

   // Saturating increment: returns {overflow_attempt, next_value}.
   // A saturated counter holds and reports the attempted increment.
   function automatic logic [32:0] sat_step(input logic [31:0] cnt, input logic inc);
      logic [32:0] res;
      res = {1'b0, cnt};
      if (inc) begin
         if (cnt == 32'hFFFF_FFFF) res = {1'b1, cnt};
         else                      res = {1'b0, cnt + 32'd1};
      end
      return res;
   endfunction

   logic        en;
   logic        irq_en;
   logic [3:0]  status;
   logic [15:0] shadow;
   logic [31:0] br_cnt;
   logic [31:0] hit_cnt;
   logic [31:0] mispr_cnt;
   logic [31:0] cyc_cnt;

   logic        sel;
   logic [3:0]  off;
   logic        rd_en;
   logic        ctrl_wr;
   logic        clr;

   logic [32:0] br_step;
   logic [32:0] hit_step;
   logic [32:0] mispr_step;
   logic [32:0] cyc_step;

   logic        en_nxt;
   logic        irq_en_nxt;
   logic [3:0]  status_nxt;
   logic [15:0] shadow_nxt;
   logic [31:0] br_nxt;
   logic [31:0] hit_nxt;
   logic [31:0] mispr_nxt;
   logic [31:0] cyc_nxt;

   assign sel     = (addr[15:4] == BASE_ADDR[15:4]);
   assign off     = addr[3:0];
   assign rd_en   = mm_re & sel;
   assign ctrl_wr = mm_we & sel & (off == 4'd0);
   assign clr     = ctrl_wr & wdata[1];

   always_comb begin
      // Counting in this cycle follows the EN value already in place; a CTRL
      // write only changes counting from the following cycle.
      br_step    = sat_step(br_cnt,    en & inc_br_cnt);
      hit_step   = sat_step(hit_cnt,   en & inc_hit_cnt);
      mispr_step = sat_step(mispr_cnt, en & inc_mispr_cnt);
      cyc_step   = sat_step(cyc_cnt,   en);

      en_nxt     = en;
      irq_en_nxt = irq_en;
      br_nxt     = br_step[31:0];
      hit_nxt    = hit_step[31:0];
      mispr_nxt  = mispr_step[31:0];
      cyc_nxt    = cyc_step[31:0];
      status_nxt = status | {cyc_step[32], mispr_step[32], hit_step[32], br_step[32]};
      shadow_nxt = shadow;

      if (rd_en) begin
         case (off)
            4'd2:    shadow_nxt = br_cnt[31:16];
            4'd4:    shadow_nxt = hit_cnt[31:16];
            4'd6:    shadow_nxt = mispr_cnt[31:16];
            4'd8:    shadow_nxt = cyc_cnt[31:16];
            default: shadow_nxt = shadow;
         endcase
      end

      if (ctrl_wr) begin
         en_nxt     = wdata[0];
         irq_en_nxt = wdata[2];
      end

      // Clear wins over any same-cycle increment, overflow or snapshot.
      if (clr) begin
         br_nxt     = 32'd0;
         hit_nxt    = 32'd0;
         mispr_nxt  = 32'd0;
         cyc_nxt    = 32'd0;
         status_nxt = 4'd0;
         shadow_nxt = 16'd0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en        <= 1'b1;
         irq_en    <= 1'b0;
         status    <= 4'd0;
         shadow    <= 16'd0;
         br_cnt    <= 32'd0;
         hit_cnt   <= 32'd0;
         mispr_cnt <= 32'd0;
         cyc_cnt   <= 32'd0;
         ovf_irq   <= 1'b0;
      end else begin
         en        <= en_nxt;
         irq_en    <= irq_en_nxt;
         status    <= status_nxt;
         shadow    <= shadow_nxt;
         br_cnt    <= br_nxt;
         hit_cnt   <= hit_nxt;
         mispr_cnt <= mispr_nxt;
         cyc_cnt   <= cyc_nxt;
         // Built from next-state values so the interrupt rises on the same
         // edge that sets the flag and drops on the edge that clears it.
         ovf_irq   <= irq_en_nxt & (|status_nxt);
      end
   end

   // Reads see pre-write state; hi offsets return the snapshot, not live data.
   always_comb begin
      rdata = 16'h0000;
      if (sel) begin
         case (off)
            4'd0:    rdata = {13'd0, irq_en, 1'b0, en};
            4'd1:    rdata = {12'd0, status};
            4'd2:    rdata = br_cnt[15:0];
            4'd3:    rdata = shadow;
            4'd4:    rdata = hit_cnt[15:0];
            4'd5:    rdata = shadow;
            4'd6:    rdata = mispr_cnt[15:0];
            4'd7:    rdata = shadow;
            4'd8:    rdata = cyc_cnt[15:0];
            4'd9:    rdata = shadow;
            default: rdata = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_br_stats_mmio.sv
module tb_br_stats_mmio;

   logic        clk;
   logic        rst;
   logic [15:0] addr;
   logic        mm_re;
   logic        mm_we;
   logic [15:0] wdata;
   logic        inc_br_cnt;
   logic        inc_hit_cnt;
   logic        inc_mispr_cnt;
   logic [15:0] rdata;
   logic        ovf_irq;

   int total = 0;
   int bad   = 0;

   br_stats_mmio #(.BASE_ADDR(16'hC010)) dut (
      .clk           (clk),
      .rst           (rst),
      .addr          (addr),
      .mm_re         (mm_re),
      .mm_we         (mm_we),
      .wdata         (wdata),
      .inc_br_cnt    (inc_br_cnt),
      .inc_hit_cnt   (inc_hit_cnt),
      .inc_mispr_cnt (inc_mispr_cnt),
      .rdata         (rdata),
      .ovf_irq       (ovf_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a read in the low phase, check the combinational data, let the edge
   // capture any snapshot, then drop the strobe.
   task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
      @(negedge clk);
      addr  = a;
      mm_re = 1'b1;
      #1;
      chk(tag, rdata, exp);
      @(posedge clk);
      #1;
      mm_re = 1'b0;
      addr  = 16'h0000;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      mm_we = 1'b1;
      @(posedge clk);
      #1;
      mm_we = 1'b0;
      addr  = 16'h0000;
      wdata = 16'h0000;
   endtask

   task automatic pulse(input logic b, input logic h, input logic m);
      @(negedge clk);
      inc_br_cnt    = b;
      inc_hit_cnt   = h;
      inc_mispr_cnt = m;
      @(posedge clk);
      #1;
      inc_br_cnt    = 1'b0;
      inc_hit_cnt   = 1'b0;
      inc_mispr_cnt = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      addr = 16'h0000;
      mm_re = 1'b0;
      mm_we = 1'b0;
      wdata = 16'h0000;
      inc_br_cnt = 1'b0;
      inc_hit_cnt = 1'b0;
      inc_mispr_cnt = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state
      rd(16'hC010, 16'h0001, "rst_ctrl");
      rd(16'hC011, 16'h0000, "rst_status");
      rd(16'hC012, 16'h0000, "rst_br_lo");
      rd(16'hC013, 16'h0000, "rst_br_hi");
      chk("rst_irq", {15'd0, ovf_irq}, 16'h0000);

      // 5 branches, hits in cycles 0-2, mispredictions in cycles 0 and 3
      pulse(1'b1, 1'b1, 1'b1);
      pulse(1'b1, 1'b1, 1'b0);
      pulse(1'b1, 1'b1, 1'b0);
      pulse(1'b1, 1'b0, 1'b1);
      pulse(1'b1, 1'b0, 1'b0);
      rd(16'hC012, 16'h0005, "br_lo");
      rd(16'hC013, 16'h0000, "br_hi");
      rd(16'hC014, 16'h0003, "hit_lo");
      rd(16'hC015, 16'h0000, "hit_hi");
      rd(16'hC016, 16'h0002, "mispr_lo");
      rd(16'hC017, 16'h0000, "mispr_hi");

      // Disabled: pulses ignored
      wr(16'hC010, 16'h0000);
      rd(16'hC010, 16'h0000, "ctrl_dis");
      for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1, 1'b1);
      rd(16'hC012, 16'h0005, "dis_br");
      rd(16'hC014, 16'h0003, "dis_hit");
      rd(16'hC016, 16'h0002, "dis_mispr");

      // Clear with EN=0: CYC must stay at 0 while disabled, then resume
      wr(16'hC010, 16'h0002);
      rd(16'hC010, 16'h0000, "ctrl_clr_reads0");
      for (int i = 0; i < 4; i++) pulse(1'b1, 1'b1, 1'b1);
      rd(16'hC018, 16'h0000, "cyc_frozen");
      rd(16'hC012, 16'h0000, "br_cleared");
      wr(16'hC010, 16'h0001);
      rd(16'hC018, 16'h0000, "cyc_after_en");
      rd(16'hC018, 16'h0001, "cyc_resumed");

      // Shadow coherency across a lo->hi carry
      @(negedge clk);
      force dut.br_cnt = 32'h0000_FFFF;
      #1;
      release dut.br_cnt;
      rd(16'hC012, 16'hFFFF, "pre_lo");
      pulse(1'b1, 1'b0, 1'b0);
      rd(16'hC013, 16'h0000, "shadow_hi");
      rd(16'hC012, 16'h0000, "carry_lo");
      rd(16'hC013, 16'h0001, "carry_hi");

      // Saturation with interrupt enabled
      wr(16'hC010, 16'h0005);
      rd(16'hC010, 16'h0005, "ctrl_irq_en");
      @(negedge clk);
      force dut.hit_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.hit_cnt;
      chk("irq_before", {15'd0, ovf_irq}, 16'h0000);
      pulse(1'b0, 1'b1, 1'b0);
      chk("irq_set", {15'd0, ovf_irq}, 16'h0001);
      rd(16'hC014, 16'hFFFF, "sat_lo");
      rd(16'hC015, 16'hFFFF, "sat_hi");
      rd(16'hC011, 16'h0002, "status_hit");
      wr(16'hC010, 16'h0007);
      chk("irq_clr", {15'd0, ovf_irq}, 16'h0000);
      rd(16'hC011, 16'h0000, "status_clr");
      rd(16'hC014, 16'h0000, "hit_clr");
      rd(16'hC010, 16'h0005, "ctrl_after_clr");

      // Clear beats a same-cycle increment
      pulse(1'b0, 1'b0, 1'b1);
      rd(16'hC016, 16'h0001, "mispr_one");
      @(negedge clk);
      addr = 16'hC010;
      wdata = 16'h0003;
      mm_we = 1'b1;
      inc_mispr_cnt = 1'b1;
      @(posedge clk);
      #1;
      mm_we = 1'b0;
      inc_mispr_cnt = 1'b0;
      addr = 16'h0000;
      wdata = 16'h0000;
      rd(16'hC016, 16'h0000, "clr_prio");
      rd(16'hC010, 16'h0001, "ctrl_final");

      // Unused offsets and out-of-window address
      for (int a = 16'hC01A; a <= 16'hC01F; a++) rd(a[15:0], 16'h0000, "unused_off");
      rd(16'hC020, 16'h0000, "out_of_window");

      // Asynchronous reset mid-operation
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      addr = 16'hC012;
      mm_re = 1'b1;
      #1;
      chk("pre_arst_br", rdata, 16'h0002);
      rst = 1'b1;
      #1;
      chk("arst_br", rdata, 16'h0000);
      addr = 16'hC010;
      #1;
      chk("arst_ctrl", rdata, 16'h0001);
      mm_re = 1'b0;
      addr = 16'h0000;
      @(negedge clk);
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
